// File: rtl/cas_sequencer.sv
// cas_sequencer
//   Column-command stage that sits after the ACT sequencer. Buffers column
//   requests, waits out tRCD per request (counted in parallel for every
//   buffered entry), spaces CAS strobes by tCCD and issues one-cycle CAS
//   strobes to the command driver. cas_idle stays low until the data burst
//   of the last issued CAS has completed, so precharge can be held off.
//
//   Build option: CAS_AUTO_PRECHARGE_EN
//     defined   - act_ap drives A10 of the CAS, and an auto-precharge WRITE
//                 holds cas_idle low 4 extra cycles for write recovery.
//     undefined - act_ap is ignored, A10 is always 0.
//
// Ports
//   clock_t   in   controller clock, all logic on the rising edge
//   reset     in   synchronous, active-high reset
//   act_rdy   in   one-cycle request strobe from the ACT stage
//   act_hit   in   row already open (no tRCD wait), valid with act_rdy
//   act_rw    in   0 = READ, 1 = WRITE, valid with act_rdy
//   act_bank  in   {bg, ba} of the request
//   act_col   in   column address
//   act_ap    in   auto-precharge request (only with CAS_AUTO_PRECHARGE_EN)
//   cas_rdy   out  one-cycle CAS command strobe
//   cas_rw    out  type of the most recent CAS, held between strobes
//   cas_bank  out  bank of the most recent CAS
//   cas_reg   out  A[14:0] of the CAS: A[9:0] = column, A10 = AP, rest 0
//   cas_idle  out  buffer empty and no burst in flight
//   buf_full  out  buffer holds DEPTH entries
//   err_ovf   out  sticky: a request arrived while the buffer was full
module cas_sequencer #(
  parameter int unsigned TRCD  = 11,
  parameter int unsigned TCCD  = 4,
  parameter int unsigned CL    = 11,
  parameter int unsigned CWL   = 9,
  parameter int unsigned BL    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        act_rdy,
  input  logic        act_hit,
  input  logic        act_rw,
  input  logic [3:0]  act_bank,
  input  logic [9:0]  act_col,
  input  logic        act_ap,
  output logic        cas_rdy,
  output logic        cas_rw,
  output logic [3:0]  cas_bank,
  output logic [14:0] cas_reg,
  output logic        cas_idle,
  output logic        buf_full,
  output logic        err_ovf
);

  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = $clog2(TRCD + 1);
  localparam int unsigned TW          = $clog2(TCCD + 1);
  localparam int unsigned RD_BURST    = CL + BL / 2 - 1;
  localparam int unsigned WR_BURST    = CWL + BL / 2 - 1;
  localparam int unsigned WR_AP_BURST = WR_BURST + 4;
  localparam int unsigned BW          = $clog2(RD_BURST + WR_AP_BURST + 1);

  // The strobe cycle itself counts toward tRCD, so the stored count starts
  // one lower than TRCD-1; the head is then eligible TRCD-1 cycles later.
  localparam logic [CW-1:0] TRCD_LOAD = CW'((TRCD > 1) ? TRCD - 2 : 0);
  localparam logic [TW-1:0] TCCD_LOAD = TW'(TCCD - 1);
  localparam logic [BW-1:0] RD_LOAD   = BW'(RD_BURST);
  localparam logic [BW-1:0] WR_LOAD   = BW'(WR_BURST);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
`ifdef CAS_AUTO_PRECHARGE_EN
  localparam logic [BW-1:0] WR_AP_LOAD = BW'(WR_AP_BURST);
`endif

  typedef enum logic [1:0] {
    CAS_IDLE  = 2'd0,
    CAS_WAIT  = 2'd1,
    CAS_CMD   = 2'd2,
    CAS_DRAIN = 2'd3
  } state_t;

  state_t state, state_next;

  logic          ent_rw   [DEPTH];
  logic [3:0]    ent_bank [DEPTH];
  logic [9:0]    ent_col  [DEPTH];
  logic [CW-1:0] ent_trcd [DEPTH];
`ifdef CAS_AUTO_PRECHARGE_EN
  logic          ent_ap   [DEPTH];
`else
  logic          unused_ap;
  assign unused_ap = act_ap;
`endif

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] tccd_cnt;
  logic [BW-1:0] burst_cnt;

  logic          full, push, pop, overflow, head_ready, fire;
  logic [BW-1:0] burst_load;
  logic          head_ap;

  always_comb begin
    full       = (count == FULL_CNT);
    pop        = (state == CAS_CMD);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    push       = act_rdy && (!full || pop);
    overflow   = act_rdy && full && !pop;
    head_ready = (count != '0) && (ent_trcd[rd_ptr] == '0) && (tccd_cnt == '0);
    fire       = 1'b0;
    state_next = state;
    buf_full   = full;
    cas_rdy    = (state == CAS_CMD);
    cas_idle   = (state == CAS_IDLE);

    case (state)
      CAS_IDLE:  if (push) state_next = CAS_WAIT;
      CAS_WAIT:  if (head_ready) begin
                   fire       = 1'b1;
                   state_next = CAS_CMD;
                 end
      CAS_CMD:   state_next = (count > 1 || push) ? CAS_WAIT : CAS_DRAIN;
      CAS_DRAIN: if (push) state_next = CAS_WAIT;
                 else if (burst_cnt == '0) state_next = CAS_IDLE;
      default:   state_next = CAS_IDLE;
    endcase
  end

  always_comb begin
`ifdef CAS_AUTO_PRECHARGE_EN
    head_ap = ent_ap[rd_ptr];
    if (ent_rw[rd_ptr]) burst_load = head_ap ? WR_AP_LOAD : WR_LOAD;
    else                burst_load = RD_LOAD;
`else
    head_ap    = 1'b0;
    burst_load = ent_rw[rd_ptr] ? WR_LOAD : RD_LOAD;
`endif
  end

  always_ff @(posedge clock_t) begin
    if (reset) state <= CAS_IDLE;
    else       state <= state_next;
  end

  // CAS fields and the tCCD/burst timers load on the edge entering CAS_CMD,
  // so the CAS cycle is the first counted cycle of both intervals.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      tccd_cnt  <= '0;
      burst_cnt <= '0;
      err_ovf   <= 1'b0;
      cas_rw    <= 1'b0;
      cas_bank  <= '0;
      cas_reg   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rw[AW'(i)]   <= 1'b0;
        ent_bank[AW'(i)] <= '0;
        ent_col[AW'(i)]  <= '0;
        ent_trcd[AW'(i)] <= '0;
`ifdef CAS_AUTO_PRECHARGE_EN
        ent_ap[AW'(i)]   <= 1'b0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_trcd[AW'(i)] != '0) ent_trcd[AW'(i)] <= ent_trcd[AW'(i)] - 1'b1;
      end

      if (push) begin
        ent_rw[wr_ptr]   <= act_rw;
        ent_bank[wr_ptr] <= act_bank;
        ent_col[wr_ptr]  <= act_col;
        ent_trcd[wr_ptr] <= act_hit ? '0 : TRCD_LOAD;
`ifdef CAS_AUTO_PRECHARGE_EN
        ent_ap[wr_ptr]   <= act_ap;
`endif
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (overflow) err_ovf <= 1'b1;

      if (fire) begin
        tccd_cnt  <= TCCD_LOAD;
        burst_cnt <= burst_load;
        cas_rw    <= ent_rw[rd_ptr];
        cas_bank  <= ent_bank[rd_ptr];
        cas_reg   <= {4'b0000, head_ap, ent_col[rd_ptr]};
      end else begin
        if (tccd_cnt != '0)  tccd_cnt  <= tccd_cnt - 1'b1;
        if (burst_cnt != '0) burst_cnt <= burst_cnt - 1'b1;
      end
    end
  end

endmodule
